// File: rtl/move_encoder.sv
// rtl/move_encoder.sv - button-to-direction encoder driving move_register, one shift per game tick
// Optional MOVE_ENC_QUEUE_EN: 2-entry turn FIFO instead of a single overwrite slot.
module move_encoder #(
    parameter int         TICK_DIV = 1000000,
    parameter logic [2:0] INIT_DIR = 3'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    output logic [2:0] load,
    output logic       shift,
    output logic [1:0] q_level
);

    localparam int             CW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [1:0]     DIR_RST = INIT_DIR[1:0];

    logic [CW-1:0] cnt;
    logic [1:0]    dir;
    logic [3:0]    btn;
    logic [3:0]    btn_prev;
    logic [3:0]    press;
    logic          press_any;
    logic [1:0]    press_dir;
    logic [1:0]    ref_dir;
    logic [1:0]    pop_dir;
    logic          tick;
    logic          valid;
    logic          pop;

    assign btn   = {btn_left, btn_down, btn_right, btn_up};
    assign press = btn & ~btn_prev;
    assign tick  = run && (cnt == CNT_MAX);
    assign load  = {1'b0, dir};

    always_comb begin
        press_any = 1'b1;
        press_dir = 2'd0;
        if (press[0])      press_dir = 2'd0;
        else if (press[1]) press_dir = 2'd1;
        else if (press[2]) press_dir = 2'd2;
        else if (press[3]) press_dir = 2'd3;
        else               press_any = 1'b0;
    end

    // Reject repeats and 180-degree reversals of the most recent accepted heading.
    assign valid = run && press_any && (press_dir != ref_dir) && (press_dir != (ref_dir ^ 2'd2));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            dir      <= DIR_RST;
            btn_prev <= 4'd0;
            shift    <= 1'b0;
        end else begin
            btn_prev <= btn;
            shift    <= tick;
            if (!run || tick) cnt <= '0;
            else              cnt <= cnt + 1'b1;
            if (pop)          dir <= pop_dir;
        end
    end

`ifdef MOVE_ENC_QUEUE_EN
    logic [1:0] q0;
    logic [1:0] q1;
    logic [1:0] q_cnt;
    logic       push;

    always_comb begin
        ref_dir = dir;
        if (q_cnt == 2'd1)      ref_dir = q0;
        else if (q_cnt == 2'd2) ref_dir = q1;
    end

    assign pop     = tick && (q_cnt != 2'd0);
    assign pop_dir = q0;
    assign push    = valid && (q_cnt != 2'd2);
    assign q_level = q_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q0    <= 2'd0;
            q1    <= 2'd0;
            q_cnt <= 2'd0;
        end else if (!run) begin
            q_cnt <= 2'd0;
        end else if (pop && push) begin
            // Push is only possible when not full, so a simultaneous pop leaves one entry.
            q0 <= press_dir;
        end else if (pop) begin
            q0    <= q1;
            q_cnt <= q_cnt - 2'd1;
        end else if (push) begin
            if (q_cnt == 2'd0) q0 <= press_dir;
            else               q1 <= press_dir;
            q_cnt <= q_cnt + 2'd1;
        end
    end
`else
    logic       pend_v;
    logic [1:0] pend_dir;

    assign ref_dir = dir;
    assign pop     = tick && pend_v;
    assign pop_dir = pend_dir;
    assign q_level = {1'b0, pend_v};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_v   <= 1'b0;
            pend_dir <= 2'd0;
        end else if (!run) begin
            pend_v <= 1'b0;
        end else if (valid) begin
            pend_v   <= 1'b1;
            pend_dir <= press_dir;
        end else if (pop) begin
            pend_v <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/move_encoder.md
# move_encoder

Write-side driver for `move_register`. Converts player button presses into direction codes and issues one `shift` pulse per game tick, so the register advances the snake body by one step each tick. Rejects 180° reversals and repeat presses, and buffers quick successive turns between ticks. Sits between the button synchronisers and `move_register`.

## Interface
- `TICK_DIV`, default 1000000: clocks per game tick; legal range ≥ 2.
- `INIT_DIR`, default 3'd1: direction after reset.
- `clk` input 1: system clock; all logic rising-edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `run` input 1: game enable; low pauses the game.
- `btn_up` input 1: synchronised button level, direction code 0.
- `btn_right` input 1: synchronised button level, direction code 1.
- `btn_down` input 1: synchronised button level, direction code 2.
- `btn_left` input 1: synchronised button level, direction code 3.
- `load` output 3: current direction code to `move_register.load`; codes 4–7 are never driven.
- `shift` output 1: one-cycle pulse, one per tick, to `move_register.shift`.
- `q_level` output 2: number of pending turns (0–2); debug only.

## Operation
- Direction codes: up=0, right=1, down=2, left=3.
  - Opposite direction of code d is `{1'b0, d[1]^1'b1, d[0]}`, i.e. d XOR 2.
- Edge detect: each button has its own registered previous level.
  - A press is a 0→1 transition seen at a clock edge.
  - If several presses occur in the same cycle, only one is taken, by priority up > right > down > left.
- Validation: the reference direction is the queue tail if the queue is non-empty, otherwise `dir`. The reference is taken from state before the current cycle's update.
  - A press equal to the reference is discarded.
  - A press equal to the opposite of the reference is discarded.
  - Any other press is valid.
- Tick counter: `cnt` counts 0..TICK_DIV-1 while `run`=1 and wraps to 0.
  - A tick occurs in the cycle where `cnt`==TICK_DIV-1.
- On a tick:
  - If the queue is non-empty, pop the head into `dir`.
  - Pulse `shift`.
- `load` always equals `dir`.
- If a pop and a valid press occur in the same cycle, both take effect. The press is validated against the pre-pop tail.
- Queue full: a valid press is dropped. No error is flagged.
- `run`=0:
  - `cnt` is held at 0 and the queue is flushed.
  - Presses are ignored (edge registers still update).
  - `dir` and `load` hold.
  - `shift` stays 0.

## Timing
- Reset values: `load`=INIT_DIR, `shift`=0, `q_level`=0, `cnt`=0, `dir`=INIT_DIR, edge registers=0.
- `shift` and `load` are registered.
  - `shift` goes high for exactly one cycle, in the cycle after `cnt`==TICK_DIV-1.
  - `load` updates to the popped direction in that same cycle, so `move_register` samples the new code with `shift`.
- Press latency: button high at edge n (low at n-1) gives `q_level` incremented at n+1.
  - The press reaches `load` on the next tick whose `cnt`==TICK_DIV-1 cycle is ≥ n+1.
- First `shift` after `run` rises: TICK_DIV cycles later.
- `shift` period is exactly TICK_DIV cycles while `run` stays high.
- Reset asserted mid-tick: all state returns to reset values immediately; no partial `shift` pulse.

## Configuration
- `MOVE_ENC_QUEUE_EN` defined: 2-entry FIFO of validated turns.
  - One entry is popped per tick.
  - A third valid press while full is dropped.
- `MOVE_ENC_QUEUE_EN` undefined: single pending slot, validated against `dir` only.
  - A later valid press overwrites an earlier one; the last valid press wins.
  - `q_level` reads 0 or 1.

## Test plan
- TICK_DIV=4, INIT_DIR=1, reset low then high, `run`=1, no buttons → `shift` high every 4th cycle, `load`=1 throughout, `q_level`=0.
- Pulse `btn_down` for one cycle mid-period → `q_level`=1 next cycle; next `shift` has `load`=2; `q_level` returns to 0.
- `dir`=1, pulse `btn_left`; also hold `btn_right` high across ticks → both presses rejected, `load` stays 1, `q_level`=0.
- Queue enabled, `dir`=1, press up then left within one period → next `shift` `load`=0, following `shift` `load`=3. With the macro undefined, the left press is validated against `dir`=1, is rejected as a reversal, and `load`=0 only.
- Queue enabled, `dir`=1, valid presses up, left, down in one period → `q_level` saturates at 2, down is dropped, the next two ticks give `load` 0 then 3.
- Pending turn queued, then `run`=0 for 10 cycles, then `run`=1 → no `shift` while paused, queue flushed (`q_level`=0), first `shift` 4 cycles after `run` rises with `load` unchanged. Repeat with `reset` asserted mid-period → outputs return to reset values immediately.
